// File: rtl/uop_sequencer.sv
// uop_sequencer: expands one decoded instruction into 1..4 sequential uops toward execute.
module uop_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rt,
  input  logic [2:0]  in_rd,
  input  logic [1:0]  in_uop_cnt,
  input  logic [15:0] in_pc,
  input  logic        flush,
  output logic        uop_valid,
  input  logic        uop_ready,
  output logic [4:0]  uop_opcode,
  output logic [2:0]  uop_rs,
  output logic [2:0]  uop_rt,
  output logic [2:0]  uop_rd,
  output logic [15:0] uop_pc,
  output logic [1:0]  uop_idx,
  output logic        uop_last,
  output logic        busy
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nx;
  logic [4:0]  opc_q;
  logic [2:0]  rs_q, rt_q, rd_q;
  logic [1:0]  cnt_q, idx_q;
  logic [15:0] pc_q;
  logic        accept;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = flush ? IDLE :
               accept ? ISSUE :
               (uop_ready & uop_last) ? IDLE : state;
  end
  // in_ready is gated by rst too so nothing is offered while reset is held
  always_comb begin
    uop_valid = state == ISSUE;
    busy      = uop_valid;
    uop_last  = uop_valid & (idx_q == cnt_q);
    in_ready  = ~rst & ~flush & ((state == IDLE) | (uop_ready & uop_last));
    accept    = in_valid & in_ready;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      opc_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      pc_q  <= '0;
      idx_q <= '0;
    end else if (flush) begin
      idx_q <= '0;
    end else if (accept) begin
      opc_q <= in_opcode;
      rs_q  <= in_rs;
      rt_q  <= in_rt;
      rd_q  <= in_rd;
      cnt_q <= in_uop_cnt;
      pc_q  <= in_pc;
      idx_q <= '0;
    end else if (uop_valid & uop_ready & ~uop_last) begin
      idx_q <= idx_q + 2'd1;
    end
  assign uop_opcode = opc_q;
  assign uop_rs     = rs_q;
  assign uop_rt     = rt_q;
  assign uop_rd     = rd_q;
  assign uop_pc     = pc_q;
  assign uop_idx    = idx_q;
endmodule

// File: tb/tb_uop_sequencer.sv
// tb_uop_sequencer: directed checks of uop expansion, stalls, back-to-back, flush and reset.
module tb_uop_sequencer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, uop_valid, uop_ready, uop_last, busy;
  logic [4:0]  in_opcode, uop_opcode;
  logic [2:0]  in_rs, in_rt, in_rd, uop_rs, uop_rt, uop_rd;
  logic [1:0]  in_uop_cnt, uop_idx;
  logic [15:0] in_pc, uop_pc;
  int n_chk = 0;
  int n_pass = 0;
  uop_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_uop_cnt(in_uop_cnt), .in_pc(in_pc), .flush(flush),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_opcode(uop_opcode),
    .uop_rs(uop_rs), .uop_rt(uop_rt), .uop_rd(uop_rd), .uop_pc(uop_pc),
    .uop_idx(uop_idx), .uop_last(uop_last), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [4:0] op, input logic [1:0] cnt, input logic [15:0] pc);
    in_valid   = 1'b1;
    in_opcode  = op;
    in_uop_cnt = cnt;
    in_pc      = pc;
    in_rs      = op[2:0];
    in_rt      = op[2:0] + 3'd1;
    in_rd      = op[2:0] + 3'd2;
  endtask
  task automatic uop(input string tag, input int unsigned op, input int unsigned idx,
                     input int unsigned last, input int unsigned pc);
    chk({tag, "_valid"}, uop_valid, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_op"}, uop_opcode, op);
    chk({tag, "_idx"}, uop_idx, idx);
    chk({tag, "_last"}, uop_last, last);
    chk({tag, "_pc"}, uop_pc, pc);
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; uop_ready = 1'b1;
    in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_uop_cnt = '0; in_pc = '0;
    step();
    offer(5'h1F, 2'd3, 16'hFFFF);
    step();
    chk("rst_valid", uop_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_last", uop_last, 0);
    chk("rst_idx", uop_idx, 0);
    chk("rst_op", uop_opcode, 0);
    chk("rst_pc", uop_pc, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    // cnt=2 with uop_ready held: three consecutive uops
    offer(5'h0A, 2'd2, 16'h0100);
    step();
    in_valid = 1'b0;
    uop("a0", 'h0A, 0, 0, 'h0100);
    chk("a0_rs", uop_rs, 2);
    chk("a0_rt", uop_rt, 3);
    chk("a0_rd", uop_rd, 4);
    chk("a0_ready", in_ready, 0);
    step();
    uop("a1", 'h0A, 1, 0, 'h0100);
    step();
    uop("a2", 'h0A, 2, 1, 'h0100);
    chk("a2_ready", in_ready, 1);
    step();
    chk("a_idle_valid", uop_valid, 0);
    chk("a_idle_busy", busy, 0);
    // stall on idx 1 for three cycles
    offer(5'h0A, 2'd2, 16'h0100);
    step();
    in_valid = 1'b0;
    uop("s0", 'h0A, 0, 0, 'h0100);
    step();
    uop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      uop("s1_hold", 'h0A, 1, 0, 'h0100);
      chk("s1_hold_rd", uop_rd, 4);
      step();
    end
    uop_ready = 1'b1;
    uop("s1_go", 'h0A, 1, 0, 'h0100);
    step();
    uop("s2", 'h0A, 2, 1, 'h0100);
    step();
    chk("s_idle", uop_valid, 0);
    // back-to-back: A cnt=1 then B cnt=0 with in_valid held
    offer(5'h01, 2'd1, 16'h0200);
    step();
    offer(5'h02, 2'd0, 16'h0300);
    uop("bb_a0", 'h01, 0, 0, 'h0200);
    chk("bb_a0_ready", in_ready, 0);
    step();
    uop("bb_a1", 'h01, 1, 1, 'h0200);
    chk("bb_a1_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    uop("bb_b0", 'h02, 0, 1, 'h0300);
    step();
    chk("bb_idle", uop_valid, 0);
    // flush during idx 1 of cnt=3
    offer(5'h03, 2'd3, 16'h0400);
    step();
    offer(5'h04, 2'd0, 16'h0500);
    uop("f0", 'h03, 0, 0, 'h0400);
    step();
    uop("f1", 'h03, 1, 0, 'h0400);
    flush = 1'b1;
    #1;
    chk("f1_flush_ready", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("f_after_valid", uop_valid, 0);
    chk("f_after_idx", uop_idx, 0);
    chk("f_after_op", uop_opcode, 'h03);
    chk("f_after_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    uop("f_new", 'h04, 0, 1, 'h0500);
    step();
    chk("f_new_idle", uop_valid, 0);
    flush = 1'b1;
    #1;
    chk("f_idle_ready", in_ready, 0);
    step();
    flush = 1'b0;
    chk("f_idle_valid", uop_valid, 0);
    // reset during idx 2 of cnt=3
    offer(5'h05, 2'd3, 16'h0600);
    step();
    in_valid = 1'b0;
    uop("r0", 'h05, 0, 0, 'h0600);
    step();
    step();
    uop("r2", 'h05, 2, 0, 'h0600);
    rst = 1'b1;
    #1;
    chk("r_rst_valid", uop_valid, 0);
    chk("r_rst_idx", uop_idx, 0);
    chk("r_rst_ready", in_ready, 0);
    chk("r_rst_op", uop_opcode, 0);
    step();
    rst = 1'b0;
    #1;
    chk("r_post_ready", in_ready, 1);
    chk("r_post_valid", uop_valid, 0);
    step();
    chk("r_post_valid2", uop_valid, 0);
    step();
    chk("r_post_valid3", uop_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uop_sequencer.md
UOP_SEQUENCER -- requirements
Module: uop_sequencer

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  decoded instruction offered by ID stage.
REQ-005 in_ready  output  1  sequencer accepts instruction this cycle.
REQ-006 in_opcode  input  5  instruction opcode.
REQ-007 in_rs / in_rt / in_rd  input  3 each  source, second source, destination register indices.
REQ-008 in_uop_cnt  input  2  number of uops minus one (0..3 means 1..4 uops).
REQ-009 in_pc  input  16  instruction PC.
REQ-010 flush  input  1  redirect or exception kill of in-flight instruction.
REQ-011 uop_valid  output  1  uop presented to execute stage.
REQ-012 uop_ready  input  1  execute stage accepts uop this cycle.
REQ-013 uop_opcode / uop_rs / uop_rt / uop_rd / uop_pc  output  5/3/3/3/16  held copies of the accepted instruction fields.
REQ-014 uop_idx  output  2  index of the current uop, 0-based.
REQ-015 uop_last  output  1  high when uop_idx equals the held uop count.
REQ-016 busy  output  1  high whenever state is ISSUE.

Function
REQ-017 FSM has two states, IDLE and ISSUE; uop_valid is 1 exactly in ISSUE, and busy equals uop_valid.
REQ-018 in_ready = (state==IDLE) | (state==ISSUE & uop_ready & uop_last), gated low whenever flush=1.
REQ-019 An instruction is accepted when in_valid & in_ready; on acceptance all fields, including cnt, are captured, idx becomes 0, and next state is ISSUE.
REQ-020 The first uop appears one cycle after acceptance; no combinational path from in_* to uop_*.
REQ-021 In ISSUE with uop_ready=0, all uop_* outputs hold stable and uop_valid stays 1.
REQ-022 In ISSUE with uop_ready=1 and uop_last=0, idx increments by 1 and the state stays ISSUE.
REQ-023 In ISSUE with uop_ready=1 and uop_last=1: if a new instruction is accepted the same cycle, capture it, set idx=0, and stay in ISSUE (back-to-back, no bubble); otherwise go to IDLE.
REQ-024 An instruction with cnt=0 issues exactly one uop with uop_last=1 and idx=0.
REQ-025 idx never exceeds cnt; there is no wrap past 3.
REQ-026 flush=1 has highest priority: next state is IDLE, idx=0, and no instruction is accepted that cycle; uop_valid is 0 the following cycle.
REQ-027 flush in IDLE is harmless and state stays IDLE.
REQ-028 Throughput is N uops in N cycles per instruction when uop_ready stays high; total instructions accepted equals the number of uop_last handshakes plus flushed instructions.

Reset
REQ-029 While rst=1: state=IDLE, idx=0, held fields=0, uop_valid=0, uop_last=0 (because idx and cnt both reset to 0 but uop_valid=0), busy=0, in_ready=0.
REQ-030 After rst deasserts, in_ready=1 from the first cycle; rst asserted mid-sequence aborts immediately and no further uop is emitted.

Verification
REQ-031 Accept opcode 5'h0A, cnt=2, pc=16'h0100, uop_ready held 1 -> uops idx 0,1,2 on three consecutive cycles starting the cycle after acceptance, uop_last only on idx 2, then IDLE.
REQ-032 Same instruction with uop_ready low on the idx-1 cycle for 3 cycles -> idx 1 and all fields hold for those 3 cycles, then idx 2 follows.
REQ-033 Instruction A (cnt=1) followed by B (cnt=0) with in_valid held -> B is accepted on A's idx-1 handshake; uop_valid stays continuous for 3 cycles: A0, A1, B0.
REQ-034 flush asserted during idx 1 of a cnt=3 instruction, with in_valid=1 -> no acceptance that cycle, uop_valid=0 next cycle, and a new instruction is accepted the cycle after.
REQ-035 rst pulsed during idx 2 of a cnt=3 instruction -> uop_valid drops immediately, idx=0, and post-reset in_ready=1 with no stale uop emitted.
